uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side UART block: a parallel-in/serial-out (PISO) byte FIFO that frames each byte and shifts it onto the serial line, one bit per baud_clk cycle. It accepts bytes from the host/SRAM side through a write handshake. It produces the frame that the receive FIFO deserialises: start bit, 8 data bits LSB first, parity bit, stop bit. It sits between the system write interface and the UART line, mirroring the receive FIFO on the far end.

Parameters:
FIFO_DEPTH_T, 16, number of 8-bit entries; power of two ≥2.
DATA_BITS, 8, data bits per frame; fixed at 8.
PARITY_EVEN, 1, 1 = even parity (bit = ^data); 0 = odd parity (bit = ~^data).

Ports:
baud_clk  in  1  bit-rate clock; one serial bit per cycle.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  push request for data_in.
data_in  in  8  parallel byte to queue.
tx_enable  in  1  peer ready (e.g. driven from the receiver's ready flag); gates frame start only.
tx_out  out  1  serial line; idle high.
TxFE  out  1  FIFO empty.
TxFF  out  1  FIFO full.
tx_busy  out  1  frame in progress (state != IDLE).
frame_done  out  1  one-cycle pulse on the cycle after the stop bit completes.
overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is baud_clk. On reset: tx_out=1, TxFE=1, TxFF=0, tx_busy=0, frame_done=0, overflow=0, pointers/count=0, state=IDLE. Reset mid-frame drops the line high immediately and discards queued data.
- Storage: wr_ptr, rd_ptr (log2 depth bits, natural wrap), count (log2 depth + 1 bits). TxFE = (count==0), TxFF = (count==FIFO_DEPTH_T); both derived from the registered count.
- Write: at an edge with wr_en=1 and TxFF=0, store data_in at wr_ptr and increment wr_ptr. With wr_en=1 and TxFF=1 the byte is dropped and overflow is set. The full check uses the registered TxFF, so a write while full is rejected even if a pop occurs on the same edge.
- Pop: occurs on the edge that enters START. It loads shift_reg from mem[rd_ptr], latches the parity bit, and increments rd_ptr.
- Count: push and pop on the same edge leave count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. tx_out is registered and reflects the current state's bit.
  - IDLE: tx_out=1. If TxFE=0 and tx_enable=1, pop and go to START.
  - START: tx_out=0 for 1 cycle, then DATA with bit_cnt=0.
  - DATA: tx_out=shift_reg[bit_cnt] for 8 cycles, LSB first. At bit_cnt==7 go to PARITY.
  - PARITY: tx_out=parity bit for 1 cycle, then STOP.
  - STOP: tx_out=1 for 1 cycle. Assert frame_done on the next cycle. If TxFE=0 and tx_enable=1, pop and go directly to START (back-to-back frames, no idle bit); otherwise go to IDLE.
- Frame timing: 11 cycles per frame. Latency from wr_en into an empty, enabled FIFO at edge k: count=1 after edge k; start bit appears after edge k+1.
- tx_enable: sampled only in IDLE/STOP. Deasserting it mid-frame does not truncate the frame.
- Full/empty boundaries: a pop leaving count=0 sets TxFE on the same edge. A push into an empty FIFO is visible to the FSM on the next edge.

Decomposition:
- Package uart_pkg: START_BIT=0, STOP_BIT=1, DATA_BITS=8, FRAME_BITS=11, tx state encoding (3-bit localparams), parity function.
- One sub-module, uart_sync_fifo: depth/width-parameterised storage with pointers, count, empty/full and overflow. uart_tx_fifo adds the framing FSM and shift register.

Test Plan:
1. Assert rst mid-run, release -> tx_out=1, TxFE=1, TxFF=0, tx_busy=0, overflow=0 on the next cycle.
2. Write 0xA5 with PARITY_EVEN=1, tx_enable=1 -> start after 2nd edge. Line sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1. frame_done pulses once; TxFE=1 after pop.
3. Set PARITY_EVEN=0 and write 0x00 -> line 0 | 0×8 | 1 | 1.
4. With tx_enable=0, write 16 bytes 0x00..0x0F -> TxFF=1 after the 16th. 17th write (0xFF) dropped and overflow=1. Raise tx_enable -> 16 back-to-back frames in 176 cycles with no idle bit between stop and start. Bytes arrive in order and 0xFF never appears. TxFE=1 after the last pop.
5. Drop tx_enable during DATA of frame 1 with 2 bytes queued -> frame 1 completes, line stays 1 and TxFE=0. Re-enable -> frame 2 starts on the next edge.
6. Assert rst asynchronously during DATA bit 4 -> tx_out=1 without waiting for a clock edge, TxFE=1, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path:
// line levels, frame geometry, FSM encoding and parity.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 1 + DATA_BITS + 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // even=1 yields even parity, even=0 odd parity
  function automatic logic parity_bit(
    input logic [DATA_BITS-1:0] d,
    input logic                 even
  );
    parity_bit = even ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered count, empty/full
// flags and a sticky overflow flag for rejected writes.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             baud_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge baud_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: queued bytes framed as start, 8 data
// bits LSB first, parity and stop, one bit per baud_clk.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH_T = 16,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS,
  parameter bit PARITY_EVEN  = 1'b1
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 TxFE,
  output logic                 TxFF,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic                 overflow
);

  import uart_pkg::*;

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rd_data;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        next_cnt;
  logic                 par_bit;
  logic                 pop;

  assign next_cnt = bit_cnt + 1'b1;
  assign pop = ((state == TX_IDLE) || (state == TX_STOP))
             && !TxFE && tx_enable;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH_T),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .baud_clk (baud_clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (data_in),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .empty    (TxFE),
    .full     (TxFF),
    .overflow (overflow)
  );

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      tx_out     <= STOP_BIT;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          tx_out  <= STOP_BIT;
          tx_busy <= 1'b0;
        end
        TX_START: begin
          state   <= TX_DATA;
          bit_cnt <= '0;
          tx_out  <= shift_reg[0];
        end
        TX_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state  <= TX_PARITY;
            tx_out <= par_bit;
          end else begin
            bit_cnt <= next_cnt;
            tx_out  <= shift_reg[next_cnt];
          end
        end
        TX_PARITY: begin
          state  <= TX_STOP;
          tx_out <= STOP_BIT;
        end
        TX_STOP: begin
          frame_done <= 1'b1;
          state      <= TX_IDLE;
          tx_out     <= STOP_BIT;
          tx_busy    <= 1'b0;
        end
        default: begin
          state   <= TX_IDLE;
          tx_out  <= STOP_BIT;
          tx_busy <= 1'b0;
        end
      endcase
      // a pop from IDLE or STOP overrides the idle return
      if (pop) begin
        state     <= TX_START;
        tx_out    <= START_BIT;
        tx_busy   <= 1'b1;
        shift_reg <= rd_data;
        par_bit   <= parity_bit(rd_data, PARITY_EVEN);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: even and odd parity
// instances, frame timing, fill/drain, enable gating, reset.
module tb_uart_tx_fifo;

  logic       baud_clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       tx_enable;
  logic       tx_out;
  logic       TxFE;
  logic       TxFF;
  logic       tx_busy;
  logic       frame_done;
  logic       overflow;

  logic       wr_en_b;
  logic [7:0] data_in_b;
  logic       tx_enable_b;
  logic       tx_out_b;
  logic       TxFE_b;
  logic       TxFF_b;
  logic       tx_busy_b;
  logic       frame_done_b;
  logic       overflow_b;

  int checks;
  int errors;

  uart_tx_fifo #(
    .FIFO_DEPTH_T (16),
    .DATA_BITS    (8),
    .PARITY_EVEN  (1'b1)
  ) dut (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .tx_enable  (tx_enable),
    .tx_out     (tx_out),
    .TxFE       (TxFE),
    .TxFF       (TxFF),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  uart_tx_fifo #(
    .FIFO_DEPTH_T (16),
    .DATA_BITS    (8),
    .PARITY_EVEN  (1'b0)
  ) dut_odd (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .wr_en      (wr_en_b),
    .data_in    (data_in_b),
    .tx_enable  (tx_enable_b),
    .tx_out     (tx_out_b),
    .TxFE       (TxFE_b),
    .TxFF       (TxFF_b),
    .tx_busy    (tx_busy_b),
    .frame_done (frame_done_b),
    .overflow   (overflow_b)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; data_in = 8'h81; tx_enable = 1'b1;
    step();
    wr_en = 1'b0;
    repeat (4) step();
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy got %b exp 1", tx_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (tx_out !== 1'b1) begin
      errors++; $display("FAIL rst_tx_out got %b exp 1", tx_out);
    end
    checks++;
    if (TxFE !== 1'b1) begin
      errors++; $display("FAIL rst_TxFE got %b exp 1", TxFE);
    end
    checks++;
    if (TxFF !== 1'b0) begin
      errors++; $display("FAIL rst_TxFF got %b exp 0", TxFF);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b exp 0", tx_busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rst_overflow got %b exp 0", overflow);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done);
    end
  endtask

  task automatic test_even_frame();
    logic [7:0] v;
    logic [7:0] rx;
    v = 8'hA5;
    tx_enable = 1'b1;
    wr_en = 1'b1; data_in = v;
    step();
    wr_en = 1'b0;
    checks++;
    if (tx_out !== 1'b1 || TxFE !== 1'b0) begin
      errors++;
      $display("FAIL even_push got tx=%b fe=%b exp tx=1 fe=0", tx_out, TxFE);
    end
    step();
    checks++;
    if (tx_out !== 1'b0 || TxFE !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL even_start got tx=%b fe=%b busy=%b exp 0 1 1",
               tx_out, TxFE, tx_busy);
    end
    for (int b = 0; b < 8; b++) begin
      step();
      rx[b] = tx_out;
    end
    checks++;
    if (rx !== 8'hA5) begin
      errors++; $display("FAIL even_data got %h exp a5", rx);
    end
    step();
    checks++;
    if (tx_out !== 1'b0) begin
      errors++; $display("FAIL even_parity got %b exp 0", tx_out);
    end
    step();
    checks++;
    if (tx_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL even_stop got tx=%b fd=%b exp 1 0", tx_out, frame_done);
    end
    step();
    checks++;
    if (frame_done !== 1'b1 || tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL even_done got fd=%b tx=%b busy=%b exp 1 1 0",
               frame_done, tx_out, tx_busy);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL even_done_pulse got %b exp 0", frame_done);
    end
  endtask

  task automatic test_odd_frame();
    logic [7:0] rx;
    tx_enable_b = 1'b1;
    wr_en_b = 1'b1; data_in_b = 8'h00;
    step();
    wr_en_b = 1'b0;
    step();
    checks++;
    if (tx_out_b !== 1'b0 || tx_busy_b !== 1'b1) begin
      errors++;
      $display("FAIL odd_start got tx=%b busy=%b exp 0 1", tx_out_b, tx_busy_b);
    end
    for (int b = 0; b < 8; b++) begin
      step();
      rx[b] = tx_out_b;
    end
    checks++;
    if (rx !== 8'h00) begin
      errors++; $display("FAIL odd_data got %h exp 00", rx);
    end
    step();
    checks++;
    if (tx_out_b !== 1'b1) begin
      errors++; $display("FAIL odd_parity got %b exp 1", tx_out_b);
    end
    step();
    checks++;
    if (tx_out_b !== 1'b1) begin
      errors++; $display("FAIL odd_stop got %b exp 1", tx_out_b);
    end
    step();
    checks++;
    if (frame_done_b !== 1'b1 || TxFE_b !== 1'b1 || TxFF_b !== 1'b0
        || overflow_b !== 1'b0) begin
      errors++;
      $display("FAIL odd_done got fd=%b fe=%b ff=%b ov=%b exp 1 1 0 0",
               frame_done_b, TxFE_b, TxFF_b, overflow_b);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] fb;
    logic [7:0] rx;
    tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step();
      if (i == 14) begin
        checks++;
        if (TxFF !== 1'b0) begin
          errors++; $display("FAIL fill_15_ff got %b exp 0", TxFF);
        end
      end
    end
    checks++;
    if (TxFF !== 1'b1 || TxFE !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_16 got ff=%b fe=%b ov=%b exp 1 0 0",
               TxFF, TxFE, overflow);
    end
    data_in = 8'hFF;
    step();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || TxFF !== 1'b1) begin
      errors++;
      $display("FAIL overflow got ov=%b ff=%b exp 1 1", overflow, TxFF);
    end
    tx_enable = 1'b1;
    step();
    for (int f = 0; f < 16; f++) begin
      fb = 8'(f);
      checks++;
      if (tx_out !== 1'b0 || frame_done !== (f > 0)
          || TxFE !== (f == 15)) begin
        errors++;
        $display("FAIL drain_start%0d got tx=%b fd=%b fe=%b", f,
                 tx_out, frame_done, TxFE);
      end
      for (int b = 0; b < 8; b++) begin
        step();
        rx[b] = tx_out;
      end
      checks++;
      if (rx !== fb) begin
        errors++; $display("FAIL drain_data%0d got %h exp %h", f, rx, fb);
      end
      step();
      checks++;
      if (tx_out !== ^fb) begin
        errors++;
        $display("FAIL drain_par%0d got %b exp %b", f, tx_out, ^fb);
      end
      step();
      checks++;
      if (tx_out !== 1'b1) begin
        errors++; $display("FAIL drain_stop%0d got %b exp 1", f, tx_out);
      end
      step();
    end
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b1
        || TxFE !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got tx=%b busy=%b fd=%b fe=%b exp 1 0 1 1",
               tx_out, tx_busy, frame_done, TxFE);
    end
  endtask

  task automatic test_enable_gap();
    logic [7:0] rx;
    tx_enable = 1'b0;
    wr_en = 1'b1; data_in = 8'h3C;
    step();
    data_in = 8'hC3;
    step();
    wr_en = 1'b0;
    tx_enable = 1'b1;
    step();
    checks++;
    if (tx_out !== 1'b0) begin
      errors++; $display("FAIL gap_start1 got %b exp 0", tx_out);
    end
    step();
    tx_enable = 1'b0;
    rx[0] = tx_out;
    for (int b = 1; b < 8; b++) begin
      step();
      rx[b] = tx_out;
    end
    checks++;
    if (rx !== 8'h3C) begin
      errors++; $display("FAIL gap_data1 got %h exp 3c", rx);
    end
    step();
    checks++;
    if (tx_out !== 1'b0) begin
      errors++; $display("FAIL gap_par1 got %b exp 0", tx_out);
    end
    step();
    step();
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || TxFE !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold got tx=%b busy=%b fe=%b exp 1 0 0",
               tx_out, tx_busy, TxFE);
    end
    repeat (3) begin
      step();
      checks++;
      if (tx_out !== 1'b1) begin
        errors++; $display("FAIL gap_idle got %b exp 1", tx_out);
      end
    end
    tx_enable = 1'b1;
    step();
    checks++;
    if (tx_out !== 1'b0 || TxFE !== 1'b1) begin
      errors++;
      $display("FAIL gap_start2 got tx=%b fe=%b exp 0 1", tx_out, TxFE);
    end
    for (int b = 0; b < 8; b++) begin
      step();
      rx[b] = tx_out;
    end
    checks++;
    if (rx !== 8'hC3) begin
      errors++; $display("FAIL gap_data2 got %h exp c3", rx);
    end
    step();
    step();
    step();
  endtask

  task automatic test_async_reset();
    tx_enable = 1'b1;
    wr_en = 1'b1; data_in = 8'h4A;
    step();
    data_in = 8'h77;
    step();
    wr_en = 1'b0;
    repeat (5) step();
    checks++;
    if (tx_out !== 1'b0 || TxFE !== 1'b0) begin
      errors++;
      $display("FAIL arst_bit4 got tx=%b fe=%b exp 0 0", tx_out, TxFE);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || TxFE !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got tx=%b fe=%b busy=%b exp 1 1 0",
               tx_out, TxFE, tx_busy);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL arst_quiet%0d got tx=%b busy=%b exp 1 0",
                 c, tx_out, tx_busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wr_en = 1'b0; data_in = 8'h00; tx_enable = 1'b0;
    wr_en_b = 1'b0; data_in_b = 8'h00; tx_enable_b = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_fill_drain();
    test_enable_gap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
